// File: rtl/rtc_i2c_master.sv
// rtl/rtc_i2c_master.sv - Avalon-MM I2C byte engine for the board RTC
//
// One command runs an optional START, one byte WRITE or READ with its ACK bit,
// then an optional STOP, and raises done_pend (irq when irq_en) on completion.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   address[2:0]            word register select: 0 DATA, 1 CMD, 2 STATUS, 3 CTRL
//   chipselect, write_n     slave select, active-low write strobe
//   writedata[31:0]         register write data
//   readdata[31:0]          registered read data, valid 1 clk after address
//   scl_oe, sda_oe          open-drain pad enables (1 = pull low)
//   scl_in, sda_in          synchronised pad sense
//   irq                     level interrupt = done_pend & irq_en
module rtc_i2c_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BYTE,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        busy_q, busy_d;
  logic        rx_nack_q, rx_nack_d;
  logic        cmd_err_q, cmd_err_d;
  logic        done_pend_q, done_pend_d;
  logic        irq_en_q, irq_en_d;
  logic        c_stop_q, c_stop_d;
  logic        c_wr_q, c_wr_d;
  logic        c_rd_q, c_rd_d;
  logic        c_nack_q, c_nack_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;
  logic [31:0] readdata_q, readdata_d;

  logic wr_en;
  logic stretch;
  logic tick;
  logic accept;

  logic unused_writedata;
  assign unused_writedata = ^writedata[31:8];

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    busy_d      = busy_q;
    rx_nack_d   = rx_nack_q;
    cmd_err_d   = cmd_err_q;
    done_pend_d = done_pend_q;
    irq_en_d    = irq_en_q;
    c_stop_d    = c_stop_q;
    c_wr_d      = c_wr_q;
    c_rd_d      = c_rd_q;
    c_nack_d    = c_nack_q;
    scl_oe_d    = scl_oe_q;
    sda_oe_d    = sda_oe_q;
    accept      = 1'b0;

    wr_en = chipselect & ~write_n;

    // SCL released but still seen low: a slave is stretching. Hold the
    // quarter counter at zero so the high time is measured from release.
    stretch = (state_q == S_BYTE) && (phase_q == 2'd2) && !scl_in;
    tick    = (div_q == DIV_LAST) && !stretch;
    div_d   = (div_q == DIV_LAST || stretch) ? 16'd0 : div_q + 16'd1;

    // W1C clears come first so same-clk set events below take priority.
    if (wr_en) begin
      case (address)
        3'd0: if (!busy_q) tx_d = writedata[7:0];
        3'd2: begin
          if (writedata[2]) cmd_err_d = 1'b0;
          if (writedata[3]) done_pend_d = 1'b0;
        end
        3'd3: irq_en_d = writedata[0];
        default: ;
      endcase
    end

    if (wr_en && address == 3'd1) begin
      if (busy_q || (writedata[2] && writedata[3])) cmd_err_d = 1'b1;
      else if (writedata[3:0] != 4'd0) accept = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          busy_d    = 1'b1;
          rx_nack_d = 1'b0;
          c_stop_d  = writedata[1];
          c_wr_d    = writedata[2];
          c_rd_d    = writedata[3];
          c_nack_d  = writedata[4];
          phase_d   = 2'd0;
          bit_d     = 4'd0;
          div_d     = 16'd0;
          if (writedata[0])                     state_d = S_START;
          else if (writedata[2] | writedata[3]) state_d = S_BYTE;
          else                                  state_d = S_STOP;
        end
      end
      S_START: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: sda_oe_d = 1'b0;
            2'd1: scl_oe_d = 1'b0;
            2'd2: sda_oe_d = 1'b1;
            2'd3: begin
              scl_oe_d = 1'b1;
              if (c_wr_q | c_rd_q) state_d = S_BYTE;
              else if (c_stop_q)   state_d = S_STOP;
              else                 state_d = S_DONE;
            end
          endcase
        end
      end
      S_BYTE: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: begin
              // Bit 8 is the ACK slot: released on WR, master ACK/NACK on RD.
              if (bit_q == 4'd8) sda_oe_d = c_rd_q & ~c_nack_q;
              else               sda_oe_d = c_wr_q & ~tx_q[~bit_q[2:0]];
            end
            2'd1: scl_oe_d = 1'b0;
            2'd2: begin
              if (bit_q == 4'd8) begin
                if (c_wr_q) rx_nack_d = sda_in;
              end else if (c_rd_q) begin
                rx_d = {rx_q[6:0], sda_in};
              end
            end
            2'd3: begin
              scl_oe_d = 1'b1;
              if (bit_q == 4'd8) begin
                bit_d   = 4'd0;
                state_d = c_stop_q ? S_STOP : S_DONE;
              end else begin
                bit_d = bit_q + 4'd1;
              end
            end
          endcase
        end
      end
      S_STOP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: scl_oe_d = 1'b0;
            2'd2: ;
            2'd3: begin
              sda_oe_d = 1'b0;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_DONE: begin
        busy_d      = 1'b0;
        done_pend_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (address)
      3'd0:    readdata_d = {24'd0, rx_q};
      3'd2:    readdata_d = {28'd0, done_pend_q, cmd_err_q, rx_nack_q, busy_q};
      3'd3:    readdata_d = {31'd0, irq_en_q};
      default: readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 2'd0;
      bit_q       <= 4'd0;
      div_q       <= 16'd0;
      tx_q        <= 8'd0;
      rx_q        <= 8'd0;
      busy_q      <= 1'b0;
      rx_nack_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      done_pend_q <= 1'b0;
      irq_en_q    <= 1'b0;
      c_stop_q    <= 1'b0;
      c_wr_q      <= 1'b0;
      c_rd_q      <= 1'b0;
      c_nack_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      readdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      busy_q      <= busy_d;
      rx_nack_q   <= rx_nack_d;
      cmd_err_q   <= cmd_err_d;
      done_pend_q <= done_pend_d;
      irq_en_q    <= irq_en_d;
      c_stop_q    <= c_stop_d;
      c_wr_q      <= c_wr_d;
      c_rd_q      <= c_rd_d;
      c_nack_q    <= c_nack_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign scl_oe   = scl_oe_q;
  assign sda_oe   = sda_oe_q;
  assign irq      = done_pend_q & irq_en_q;

endmodule

// File: tb/tb_rtc_i2c_master.sv
// tb/tb_rtc_i2c_master.sv - self-checking bench for rtc_i2c_master
`timescale 1ns/1ps
module tb_rtc_i2c_master;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        scl_oe, sda_oe, scl_in, sda_in, irq;

  int errors = 0;
  int checks = 0;

  // Open-drain bus with a simple slave device model.
  logic       scl_hold = 1'b0;
  logic       slv_sda_low;
  logic       rd_pending = 1'b0;
  logic       slave_ack = 1'b1;
  logic [7:0] slave_tx = 8'd0;
  int         fall_cnt = -1;
  logic [7:0] cap = 8'd0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       stop_seen = 1'b0;
  logic       ack_bit = 1'b0;
  logic       stretch_arm = 1'b0;
  int         stretch_cnt = 0;

  logic [7:0] wr_q[$];
  logic [7:0] rd_q[$];

  assign scl_in = ~(scl_oe | scl_hold);
  assign sda_in = ~(sda_oe | slv_sda_low);

  always #5 clk = ~clk;

  rtc_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in), .irq(irq)
  );

  always_comb begin
    slv_sda_low = 1'b0;
    if (rd_pending && fall_cnt >= 0 && fall_cnt < 8) slv_sda_low = ~slave_tx[7 - fall_cnt];
    else if (!rd_pending && fall_cnt == 8 && slave_ack) slv_sda_low = 1'b1;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      fall_cnt   = -1;
      rd_pending = 1'b0;
      scl_hold   = 1'b0;
      prev_scl   = scl_in;
      prev_sda   = sda_in;
    end else begin
      if (prev_scl && scl_in && prev_sda && !sda_in) begin
        fall_cnt = -1;
        cap = 8'd0;
      end else if (prev_scl && scl_in && !prev_sda && sda_in) begin
        stop_seen = 1'b1;
        fall_cnt = -1;
      end
      if (!prev_scl && scl_in) begin
        if (fall_cnt >= 0 && fall_cnt < 8) begin
          cap = {cap[6:0], sda_in};
          if (fall_cnt == 7 && !rd_pending) begin
            checks++;
            if (wr_q.size() == 0) begin
              errors++;
              $display("FAIL bus_byte: unexpected byte 0x%02h on bus, none expected", cap);
            end else begin
              logic [7:0] exp_b;
              exp_b = wr_q.pop_front();
              if (cap !== exp_b) begin
                errors++;
                $display("FAIL bus_byte: got 0x%02h want 0x%02h", cap, exp_b);
              end
            end
          end
        end else if (fall_cnt == 8) begin
          ack_bit = sda_in;
        end
      end
      if (prev_scl && !scl_in) begin
        if (fall_cnt == 8) begin
          fall_cnt = 0;
          rd_pending = 1'b0;
        end else begin
          fall_cnt++;
        end
      end
      prev_scl = scl_in;
      prev_sda = sda_in;
      if (stretch_arm && !scl_hold && fall_cnt == 3) scl_hold = 1'b1;
      if (scl_hold) begin
        if (!scl_oe) stretch_cnt++;
        if (stretch_cnt >= 300) begin
          scl_hold = 1'b0;
          stretch_arm = 1'b0;
        end
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk);
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  // Polls STATUS every clk (readdata lags busy by one clk) and counts busy cycles.
  task automatic wait_done(output int cyc);
    int guard;
    cyc = 0;
    guard = 0;
    address = 3'd2; chipselect = 1'b1; write_n = 1'b1;
    while (guard < 4000) begin
      @(negedge clk);
      guard++;
      if (readdata[0]) cyc++;
      else if (cyc > 0) break;
    end
    chipselect = 1'b0;
    if (guard >= 4000) begin
      checks++; errors++;
      $display("FAIL wait_done: busy not cleared after %0d cycles (busy count %0d)", guard, cyc);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({readdata, scl_oe, sda_oe, irq} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: readdata=0x%08h scl_oe=%b sda_oe=%b irq=%b want all 0", readdata, scl_oe, sda_oe, irq);
    end
    reset_n = 1'b1;
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_data: got 0x%08h want 0x00000000", rd); end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got 0x%08h want 0x00000000", rd); end
    bus_write(3'd7, 32'd1);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl_addr7: got 0x%08h want 0x00000000", rd); end
  endtask

  task automatic test_reset_mid_byte();
    logic [31:0] rd;
    bus_write(3'd0, 32'h00);
    bus_write(3'd1, 32'h05);
    repeat (60) @(negedge clk);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL t1_in_byte: sda_oe=%b want 1", sda_oe); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({scl_oe, sda_oe, readdata} !== 34'd0) begin
      errors++;
      $display("FAIL t1_async_reset: scl_oe=%b sda_oe=%b readdata=0x%08h want all 0", scl_oe, sda_oe, readdata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL t1_status: got 0x%08h want 0x00000000", rd); end
  endtask

  task automatic test_write_ack();
    logic [31:0] rd;
    int cyc;
    slave_ack = 1'b1;
    bus_write(3'd0, 32'hD0);
    wr_q.push_back(8'hD0);
    bus_write(3'd1, 32'h05);
    wait_done(cyc);
    checks++;
    if (cyc != 40 * CLK_DIV + 1) begin errors++; $display("FAIL t2_busy_cycles: got %0d want %0d", cyc, 40 * CLK_DIV + 1); end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h8) begin errors++; $display("FAIL t2_status: got 0x%08h want 0x00000008", rd); end
    checks++;
    if (scl_oe !== 1'b1) begin errors++; $display("FAIL t2_scl_left_low: scl_oe=%b want 1", scl_oe); end
    bus_write(3'd2, 32'h8);
  endtask

  task automatic test_read_nack_stop();
    logic [31:0] rd;
    int cyc;
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL t3_ctrl: got 0x%08h want 0x00000001", rd); end
    slave_tx = 8'h59;
    rd_pending = 1'b1;
    stop_seen = 1'b0;
    rd_q.push_back(8'h59);
    bus_write(3'd1, 32'h1A);
    wait_done(cyc);
    checks++;
    if (cyc != 40 * CLK_DIV + 1) begin errors++; $display("FAIL t3_busy_cycles: got %0d want %0d", cyc, 40 * CLK_DIV + 1); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL t3_irq: got %b want 1", irq); end
    bus_read(3'd0, rd);
    checks++;
    begin
      logic [7:0] exp_b;
      exp_b = rd_q.pop_front();
      if (rd !== {24'd0, exp_b}) begin errors++; $display("FAIL t3_rx_data: got 0x%08h want 0x%08h", rd, {24'd0, exp_b}); end
    end
    checks++;
    if (ack_bit !== 1'b1) begin errors++; $display("FAIL t3_master_nack: ack slot SDA=%b want 1", ack_bit); end
    checks++;
    if (stop_seen !== 1'b1) begin errors++; $display("FAIL t3_stop: stop_seen=%b want 1", stop_seen); end
    bus_write(3'd2, 32'h8);
  endtask

  task automatic test_write_nack();
    logic [31:0] rd;
    int cyc;
    slave_ack = 1'b0;
    bus_write(3'd0, 32'hA0);
    wr_q.push_back(8'hA0);
    bus_write(3'd1, 32'h07);
    wait_done(cyc);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'hA) begin errors++; $display("FAIL t4_status: got 0x%08h want 0x0000000a", rd); end
    @(negedge clk);
    address = 3'd2; writedata = 32'h8; chipselect = 1'b1; write_n = 1'b0;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL t4_irq_before: got %b want 1", irq); end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL t4_irq_drop: got %b want 0", irq); end
    chipselect = 1'b0; write_n = 1'b1;
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL t4_status_w1c: got 0x%08h want 0x00000002", rd); end
    slave_ack = 1'b1;
  endtask

  task automatic test_cmd_errors();
    logic [31:0] rd;
    int cyc;
    int changes;
    logic scl0, sda0;
    bus_write(3'd0, 32'h3C);
    wr_q.push_back(8'h3C);
    bus_write(3'd1, 32'h07);
    repeat (10) @(negedge clk);
    bus_write(3'd1, 32'h08);
    bus_write(3'd0, 32'hFF);
    wait_done(cyc);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'hC) begin errors++; $display("FAIL t5_busy_err: got 0x%08h want 0x0000000c", rd); end
    bus_write(3'd2, 32'hC);
    scl0 = scl_oe; sda0 = sda_oe;
    bus_write(3'd1, 32'h0C);
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (scl_oe !== scl0 || sda_oe !== sda0) changes++;
    end
    checks++;
    if (changes != 0) begin errors++; $display("FAIL t5_no_activity: %0d pad changes want 0", changes); end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL t5_wrrd_err: got 0x%08h want 0x00000004", rd); end
    bus_write(3'd1, 32'h10);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL t5_empty_cmd: got 0x%08h want 0x00000004", rd); end
    bus_write(3'd2, 32'h4);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL t5_err_w1c: got 0x%08h want 0x00000000", rd); end
  endtask

  task automatic test_clock_stretch();
    logic [31:0] rd;
    int cyc;
    int base;
    base = 44 * CLK_DIV + 1;
    bus_write(3'd0, 32'hA5);
    wr_q.push_back(8'hA5);
    stretch_cnt = 0;
    stretch_arm = 1'b1;
    bus_write(3'd1, 32'h07);
    wait_done(cyc);
    checks++;
    if (stretch_arm !== 1'b0) begin errors++; $display("FAIL t6_stretch_engaged: arm=%b want 0", stretch_arm); end
    checks++;
    if (cyc < base + 300 - CLK_DIV || cyc > base + 300 + CLK_DIV) begin
      errors++;
      $display("FAIL t6_busy_cycles: got %0d want %0d..%0d", cyc, base + 300 - CLK_DIV, base + 300 + CLK_DIV);
    end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h8) begin errors++; $display("FAIL t6_status: got 0x%08h want 0x00000008", rd); end
    bus_write(3'd2, 32'h8);
  endtask

  initial begin
    test_reset();
    test_reset_mid_byte();
    test_write_ack();
    test_read_nack_stop();
    test_write_nack();
    test_cmd_errors();
    test_clock_stretch();
    checks++;
    if (wr_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expected bytes never seen, want 0", wr_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
